// File: rtl/nios_dip_pkg.sv
// Shared constants and types for the DIP switch controller: register map,
// debounce FSM states and the debounce period width.
package nios_dip_pkg;
  localparam int PER_W = 16;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_PER  = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } deb_state_e;
endpackage

// File: rtl/nios_dip_ctrl_if.sv
// Avalon-MM slave bus of the DIP switch controller.
interface nios_dip_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/nios_dip_debounce.sv
// One switch bit: 2-flop synchronizer, IDLE/CHECK debounce FSM and counter.
// o_toggle pulses in the cycle the stable value flips.
module nios_dip_debounce
  import nios_dip_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_raw,
  input  logic [PER_W-1:0] i_period,
  output logic             o_stable,
  output logic             o_toggle
);
  logic             r_sync1, r_sync2, r_stable;
  logic [PER_W-1:0] r_cnt, w_cnt_nxt, w_per;
  deb_state_e       r_state, w_state_nxt;
  logic             w_toggle;

  // A zero period behaves as one so a change always needs a confirming cycle.
  assign w_per = (i_period == '0) ? PER_W'(1) : i_period;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_state  <= IDLE;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_cnt   <= w_cnt_nxt;
      r_state <= w_state_nxt;
      if (w_toggle) r_stable <= ~r_stable;
    end
  end

  // >= compare lets a shortened period end a count already in progress.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_toggle    = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_sync2 != r_stable) begin
          w_state_nxt = CHECK;
          w_cnt_nxt   = PER_W'(1);
        end
      end
      CHECK: begin
        if (r_sync2 == r_stable) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= w_per) begin
          w_toggle    = 1'b1;
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + PER_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_stable = r_stable;
  assign o_toggle = w_toggle;
endmodule

// File: rtl/nios_dip_ctrl.sv
// Debounced DIP switch PIO with edge capture and optional masked interrupt.
// Define NIOS_DIP_IRQ_EN to build the irq mask register and irq output.
module nios_dip_ctrl
  import nios_dip_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [PER_W-1:0] DEB_RESET = 16'd1000
) (
  input  logic              clk,
  input  logic              reset_n,
  nios_dip_ctrl_if.slave    avs,
  input  logic [WIDTH-1:0]  in_port,
  output logic              irq
);
  logic [WIDTH-1:0] w_stable, w_toggle, w_clr, w_mask;
  logic [WIDTH-1:0] r_edge;
  logic [PER_W-1:0] r_period;
  logic [31:0]      r_readdata;
  logic             w_wr;

  genvar g;
  generate
    for (g = 0; g < WIDTH; g++) begin : g_bit
      nios_dip_debounce u_deb (
        .clk     (clk),
        .reset_n (reset_n),
        .i_raw   (in_port[g]),
        .i_period(r_period),
        .o_stable(w_stable[g]),
        .o_toggle(w_toggle[g])
      );
    end
  endgenerate

  assign w_wr  = avs.chipselect && !avs.write_n;
  assign w_clr = (w_wr && avs.address == ADDR_EDGE) ? avs.writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_edge   <= '0;
      r_period <= DEB_RESET;
    end else begin
      // New edge ORed in after the clear so a coincident set wins.
      r_edge <= (r_edge & ~w_clr) | w_toggle;
      if (w_wr && avs.address == ADDR_PER) r_period <= avs.writedata[PER_W-1:0];
    end
  end

`ifdef NIOS_DIP_IRQ_EN
  logic [WIDTH-1:0] r_mask;
  logic             r_irq;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mask <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_irq <= |(r_edge & r_mask);
      if (w_wr && avs.address == ADDR_MASK) r_mask <= avs.writedata[WIDTH-1:0];
    end
  end

  assign w_mask = r_mask;
  assign irq    = r_irq;
`else
  assign w_mask = '0;
  assign irq    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      case (avs.address)
        ADDR_DATA: r_readdata <= 32'(w_stable);
        ADDR_MASK: r_readdata <= 32'(w_mask);
        ADDR_EDGE: r_readdata <= 32'(r_edge);
        default:   r_readdata <= 32'(r_period);
      endcase
    end
  end

  assign avs.readdata = r_readdata;
endmodule

// File: tb/tb_nios_dip_ctrl.sv
// Bench for nios_dip_ctrl: directed register/latency cases plus random
// switch and bus traffic checked every cycle against a run-length model.
module tb_nios_dip_ctrl;
  localparam int          W   = 4;
  localparam logic [15:0] DEB = 16'd1000;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] in_port = '0;
  logic         irq;

  nios_dip_ctrl_if avs ();

  nios_dip_ctrl #(.WIDTH(W), .DEB_RESET(DEB)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .avs    (avs),
    .in_port(in_port),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: a raw value is accepted once its synchronized copy has
  // disagreed with the stable value for P+1 consecutive clocks.
  logic [W-1:0] m_s1, m_s2, m_stb, m_cap, m_mask, m_set, m_clr;
  int           m_run [W];
  logic [15:0]  m_per;
  logic [31:0]  m_rd, m_rdn;
  logic         m_irq, m_wr, m_live = 1'b0;
  int           m_p;

  always @(posedge clk) begin
    m_live = 1'b1;
    if (!reset_n) begin
      m_s1 = '0; m_s2 = '0; m_stb = '0; m_cap = '0; m_mask = '0;
      m_per = DEB; m_rd = '0; m_irq = 1'b0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      m_wr = avs.chipselect && !avs.write_n;
      case (avs.address)
        2'd0:    m_rdn = 32'(m_stb);
        2'd1:    m_rdn = 32'(m_mask);
        2'd2:    m_rdn = 32'(m_cap);
        default: m_rdn = 32'(m_per);
      endcase
      m_irq = |(m_cap & m_mask);
      m_p   = (m_per == 0) ? 1 : int'(m_per);
      m_set = '0;
      for (int i = 0; i < W; i++) begin
        if (m_s2[i] != m_stb[i]) begin
          m_run[i]++;
          if (m_run[i] >= m_p + 1) begin
            m_stb[i] = ~m_stb[i];
            m_set[i] = 1'b1;
            m_run[i] = 0;
          end
        end else m_run[i] = 0;
      end
      m_clr = (m_wr && avs.address == 2'd2) ? avs.writedata[W-1:0] : '0;
      m_cap = (m_cap & ~m_clr) | m_set;
`ifdef NIOS_DIP_IRQ_EN
      if (m_wr && avs.address == 2'd1) m_mask = avs.writedata[W-1:0];
`endif
      if (m_wr && avs.address == 2'd3) m_per = avs.writedata[15:0];
      m_s2 = m_s1;
      m_s1 = in_port;
      m_rd = m_rdn;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("rd_model", avs.readdata, m_rd);
      chk("irq_model", 32'(irq), 32'(m_irq));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    avs.address    = a;
    avs.writedata  = d;
    avs.chipselect = 1'b1;
    avs.write_n    = 1'b0;
    tick(1);
    avs.chipselect = 1'b0;
    avs.write_n    = 1'b1;
  endtask

  initial begin
    avs.address    = 2'd3;
    avs.chipselect = 1'b0;
    avs.write_n    = 1'b1;
    avs.writedata  = '0;
    tick(3);
    chk("rst_rd", avs.readdata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    reset_n = 1'b1;
    tick(1);
    chk("per_rst", avs.readdata, 32'd1000);

    // Period 3: stable bit flips on the 6th clock, readdata shows it one later.
    wr(2'd3, 32'd3);
    avs.address = 2'd0;
    tick(1);
    in_port = 4'b0001;
    tick(6);
    chk("deb_early", avs.readdata, 32'd0);
    tick(1);
    chk("deb_lat", avs.readdata, 32'd1);
    avs.address = 2'd2;
    tick(1);
    chk("cap0", avs.readdata, 32'd1);
    wr(2'd2, 32'd1);
    tick(1);
    chk("cap_clr", avs.readdata, 32'd0);

    in_port = 4'b0101;
    tick(2);
    in_port = 4'b0001;
    tick(10);
    chk("glitch_cap", avs.readdata, 32'd0);
    avs.address = 2'd0;
    tick(1);
    chk("glitch_data", avs.readdata, 32'd1);

`ifdef NIOS_DIP_IRQ_EN
    wr(2'd1, 32'd1);
    in_port = 4'b0000;
    tick(6);
    chk("irq_early", 32'(irq), 32'd0);
    tick(1);
    chk("irq_set", 32'(irq), 32'd1);
    wr(2'd2, 32'd1);
    chk("irq_hold", 32'(irq), 32'd1);
    tick(1);
    chk("irq_clr", 32'(irq), 32'd0);
`else
    in_port = 4'b0000;
    tick(7);
    chk("irq_off", 32'(irq), 32'd0);
    wr(2'd2, 32'd1);
    wr(2'd1, 32'hF);
    avs.address = 2'd1;
    tick(1);
    chk("mask_rd0", avs.readdata, 32'd0);
`endif

    // Clear of bit1 lands on the same clock as its new edge.
    avs.address = 2'd2;
    in_port = 4'b0010;
    tick(5);
    wr(2'd2, 32'd2);
    tick(1);
    chk("rw1c_race", avs.readdata & 32'd2, 32'd2);
    wr(2'd2, 32'd2);
    tick(1);
    chk("rw1c_clr", avs.readdata & 32'd2, 32'd0);

    wr(2'd3, 32'd0);
    avs.address = 2'd0;
    tick(1);
    in_port = 4'b1010;
    tick(4);
    chk("p0_early", avs.readdata & 32'd8, 32'd0);
    tick(1);
    chk("p0_lat", avs.readdata & 32'd8, 32'd8);
`ifndef NIOS_DIP_IRQ_EN
    chk("p0_irq", 32'(irq), 32'd0);
`endif

    wr(2'd3, 32'd2);
    for (int c = 0; c < 3000; c++) begin
      reset_n = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 9) == 0) in_port = in_port ^ W'($urandom);
      avs.address    = 2'($urandom);
      avs.chipselect = ($urandom_range(0, 5) == 0);
      avs.write_n    = !(avs.chipselect && ($urandom_range(0, 1) == 1));
      avs.writedata  = (avs.address == 2'd3) ? 32'($urandom_range(0, 5)) : $urandom;
      tick(1);
    end
    reset_n        = 1'b1;
    avs.chipselect = 1'b0;
    avs.write_n    = 1'b1;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
